// File: rtl/stall_scheduler.sv
// Decode-side hazard sequencer: classifies the IF/ID opcode and freezes the front end
// for a class-specific number of cycles, with jump flush, load timeout and stall counter.
module stall_scheduler #(
    parameter int unsigned JUMP_STALL   = 2,
    parameter int unsigned BRANCH_STALL = 1,
    parameter int unsigned MAX_WAIT     = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:5]  op,
    input  logic        op_valid,
    input  logic        mem_ack,
    output logic        stall,
    output logic        stall_pm,
    output logic        flush,
    output logic        err,
    output logic [15:0] stall_cycles
);

    localparam logic [5:0] OP_LOAD   = 6'b010100;
    localparam logic [5:0] OP_JUMP   = 6'b011110;
    localparam logic [5:0] OP_BRANCH = 6'b010001;

    localparam logic [3:0] JUMP_CNT   = 4'(JUMP_STALL - 1);
    localparam logic [3:0] BRANCH_CNT = 4'(BRANCH_STALL - 1);
    localparam logic [3:0] WAIT_CNT   = 4'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StWaitMem
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic        err_q, err_d;
    logic        stall_pm_q;
    logic [15:0] stall_cycles_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_d = 1'b0;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (op_valid) begin
                    if (op == OP_JUMP) begin
                        state_d = StHold;
                        cnt_d   = JUMP_CNT;
                        flush_d = 1'b1;
                    end else if (op == OP_BRANCH) begin
                        state_d = StHold;
                        cnt_d   = BRANCH_CNT;
                    end else if (op == OP_LOAD) begin
                        state_d = StWaitMem;
                        cnt_d   = WAIT_CNT;
                    end
                end
            end
            StHold: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWaitMem: begin
                // An ack arriving on the timeout cycle still counts as a clean completion.
                if (mem_ack) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            cnt_q          <= 4'd0;
            flush_q        <= 1'b0;
            err_q          <= 1'b0;
            stall_pm_q     <= 1'b0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            err_q      <= err_d;
            stall_pm_q <= stall;
            if (stall && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
        end
    end

    assign stall        = (state_q != StIdle);
    assign stall_pm     = stall_pm_q;
    assign flush        = flush_q;
    assign err          = err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_stall_scheduler.sv
// Scoreboard bench for stall_scheduler: per-cycle expected outputs are queued as stimulus
// is driven and compared on the falling edge.
module tb_stall_scheduler;

    localparam logic [5:0] LOAD   = 6'b010100;
    localparam logic [5:0] JUMP   = 6'b011110;
    localparam logic [5:0] BRANCH = 6'b010001;
    localparam logic [5:0] NOP    = 6'b000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:5]  op;
    logic        op_valid;
    logic        mem_ack;
    logic        stall;
    logic        stall_pm;
    logic        flush;
    logic        err;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    stall_scheduler #(
        .JUMP_STALL  (2),
        .BRANCH_STALL(1),
        .MAX_WAIT    (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .op_valid    (op_valid),
        .mem_ack     (mem_ack),
        .stall       (stall),
        .stall_pm    (stall_pm),
        .flush       (flush),
        .err         (err),
        .stall_cycles(stall_cycles)
    );

    typedef struct packed {
        logic        s;
        logic        pm;
        logic        fl;
        logic        er;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_prev_stall;
    logic exp_err;
    int   exp_sc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic es, input logic ef);
        exp_t e;
        e.s  = es;
        e.pm = exp_prev_stall;
        e.fl = ef;
        e.er = exp_err;
        e.sc = 16'(exp_sc);
        sb.push_back(e);
        exp_prev_stall = es;
        if (es) exp_sc++;
    endtask

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input logic [5:0] o, input logic v, input logic a,
                        input logic es, input logic ef);
        @(posedge clk);
        #1;
        op       = o;
        op_valid = v;
        mem_ack  = a;
        push_exp(es, ef);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_stall_pm"}, 32'(stall_pm), 32'd0);
        check({tag, "_flush"}, 32'(flush), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_cycles"}, 32'(stall_cycles), 32'd0);
    endtask

    task automatic clear_model();
        exp_err        = 1'b0;
        exp_sc         = 0;
        exp_prev_stall = 1'b0;
    endtask

    task automatic reset_pulse_with_load();
        @(posedge clk);
        #1;
        op       = LOAD;
        op_valid = 1'b1;
        mem_ack  = 1'b0;
        #1 reset = 1'b0;
        #1 check_all_zero("rst_pulse_a");
        #1 check_all_zero("rst_pulse_b");
        reset = 1'b1;
        clear_model();
        push_exp(1'b0, 1'b0);
    endtask

    task automatic reset_mid_wait();
        @(posedge clk);
        #1;
        op       = NOP;
        op_valid = 1'b1;
        mem_ack  = 1'b0;
        check("mid_pre_stall", 32'(stall), 32'd1);
        #1 reset = 1'b0;
        #1 check_all_zero("rst_mid");
        #1 reset = 1'b1;
        clear_model();
        push_exp(1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("stall", 32'(stall), 32'(mon_e.s));
            check("stall_pm", 32'(stall_pm), 32'(mon_e.pm));
            check("flush", 32'(flush), 32'(mon_e.fl));
            check("err", 32'(err), 32'(mon_e.er));
            check("stall_cycles", 32'(stall_cycles), 32'(mon_e.sc));
        end
    end

    initial begin
        reset    = 1'b0;
        op       = NOP;
        op_valid = 1'b0;
        mem_ack  = 1'b0;
        clear_model();
        #12;
        check_all_zero("reset_init");
        reset = 1'b1;

        step(NOP, 1'b1, 1'b0, 1'b0, 1'b0);
        step(NOP, 1'b1, 1'b0, 1'b0, 1'b0);

        // Jump: stall cycles 1-2, flush cycle 1, stall_pm cycles 2-3.
        step(JUMP, 1'b1, 1'b0, 1'b0, 1'b0);
        step(NOP,  1'b1, 1'b0, 1'b1, 1'b1);
        step(NOP,  1'b1, 1'b0, 1'b1, 1'b0);
        step(NOP,  1'b1, 1'b0, 1'b0, 1'b0);
        step(NOP,  1'b1, 1'b0, 1'b0, 1'b0);

        // Load released by an ack in cycle 3.
        step(LOAD, 1'b1, 1'b0, 1'b0, 1'b0);
        step(NOP,  1'b0, 1'b0, 1'b1, 1'b0);
        step(NOP,  1'b0, 1'b0, 1'b1, 1'b0);
        step(NOP,  1'b0, 1'b1, 1'b1, 1'b0);
        step(NOP,  1'b1, 1'b0, 1'b0, 1'b0);
        // Ack while idle is ignored.
        step(NOP,  1'b1, 1'b1, 1'b0, 1'b0);
        step(NOP,  1'b1, 1'b0, 1'b0, 1'b0);

        // Branch then a frozen jump: stall 1,0,1,1 with flush on the third.
        step(BRANCH, 1'b1, 1'b0, 1'b0, 1'b0);
        step(JUMP,   1'b1, 1'b0, 1'b1, 1'b0);
        step(JUMP,   1'b1, 1'b0, 1'b0, 1'b0);
        step(NOP,    1'b1, 1'b0, 1'b1, 1'b1);
        step(NOP,    1'b1, 1'b0, 1'b1, 1'b0);
        step(NOP,    1'b1, 1'b0, 1'b0, 1'b0);

        // Load timeout after 15 stalled cycles; err sticks, a branch still stalls.
        step(LOAD, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step(LOAD, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        exp_err = 1'b1;
        step(BRANCH, 1'b1, 1'b0, 1'b0, 1'b0);
        step(NOP,    1'b1, 1'b0, 1'b1, 1'b0);
        step(NOP,    1'b1, 1'b0, 1'b0, 1'b0);
        step(NOP,    1'b1, 1'b0, 1'b0, 1'b0);

        // Short reset mid-cycle with a load present: no stall until the next edge samples it.
        reset_pulse_with_load();
        step(NOP, 1'b1, 1'b1, 1'b1, 1'b0);
        step(NOP, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in cycle 2 of a load abandons the wait.
        step(LOAD, 1'b1, 1'b0, 1'b0, 1'b0);
        step(NOP,  1'b1, 1'b0, 1'b1, 1'b0);
        reset_mid_wait();
        step(NOP,  1'b1, 1'b0, 1'b0, 1'b0);
        step(NOP,  1'b1, 1'b0, 1'b0, 1'b0);

        // Load opcode marked as a bubble is not a hazard.
        step(LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
        step(LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
        step(NOP,  1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
